cmos_xor_array: RTL and testbench
=================================

// Module: cmos_xor_array
// PURPOSE
//  Registered WIDTH-bit bitwise XOR unit; each bit slice is a transistor-level CMOS cell built only from
//  nmos/pmos switch primitives on supply1/supply0 rails.
//  Sits in the switch-level cell library as the clocked wrapper used to check transistor XOR topology
//  against RTL; also provides a registered even-parity of the result.
// PARAMETERS
//  WIDTH  8  number of independent XOR bit slices (>=1)
// PORTS
//  clk        input   1      rising-edge clock
//  rst_n      input   1      asynchronous, active-low reset
//  in_valid   input   1      operands a/b valid this cycle
//  a          input   WIDTH  operand A
//  b          input   WIDTH  operand B
//  y          output  WIDTH  registered a^b
//  parity     output  1      registered XOR-reduction of the captured y (1 = odd number of ones)
//  out_valid  output  1      y/parity updated from operands of previous in_valid cycle
// BEHAVIOUR
//  Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//  Bit slice i, 14 transistors, all switch primitives, no continuous assigns or behavioural XOR in the datapath:
//   - input inverters: pmos/nmos pair per operand -> na=~a[i], nb=~b[i]
//   - pull-up: p1(gate na) || p2(gate b[i]) from vdd to node u; p3(gate a[i]) || p4(gate nb) from u to x
//   - pull-down: n1(gate b[i]) in series with n2(gate na) x->gnd; n3(gate nb) in series with n4(gate a[i]) x->gnd
//   - node x = XNOR(a[i],b[i]); output inverter p5/n5 drives s[i] = ~x = a[i]^b[i]
//   - primitives instantiated at module scope (generate loop), never inside initial/always
//  Combinational s[WIDTH-1:0] settles within the same cycle; no timing delays on primitives.
//  Registers (async clear):
//   - rst_n low (any time, no clock needed): y=0, parity=0, out_valid=0 immediately
//   - rising clk, rst_n high, in_valid=1: y<=s; parity<=^s; out_valid<=1
//   - rising clk, rst_n high, in_valid=0: y and parity hold; out_valid<=0
//  Latency: exactly 1 cycle from in_valid sample to out_valid/y; full throughput, one result per cycle.
//  No backpressure; out_valid is a 1-cycle pulse per accepted operand set, consecutive when in_valid stays high.
//  Reset deassertion: first capture happens on first rising clk with rst_n high and in_valid=1.
//  Reset mid-stream: in-flight result discarded; out_valid stays 0 until a new in_valid after release.
//  X/Z on a or b bits: the affected slice may yield X; y stores it unchanged, no masking logic;
//   unaffected slices must be exact.
//  parity is computed from s at capture time, never from the held y.
// TESTING
//  Exhaustive slice: WIDTH=8, apply all 4 (a[i],b[i]) combos on every bit with in_valid=1
//   -> next cycle y equals a^b (e.g. a=8'hF0,b=8'hCC -> y=8'h3C, parity=0).
//  Random 1000 vectors vs behavioural a^b and ^(a^b), back-to-back in_valid
//   -> out_valid high every cycle, zero mismatches.
//  Hold: capture a=8'hAA,b=8'h55 (y=8'hFF, parity=0), then in_valid=0 with new a/b
//   -> y stays 8'hFF, out_valid 0.
//  Async reset: assert rst_n=0 mid-cycle after y=8'h3C -> y=0, parity=0, out_valid=0 before next clk edge;
//   release, no in_valid -> outputs stay 0.
//  Odd parity: a=8'h01,b=8'h00 -> y=8'h01, parity=1; a=b=8'h5A -> y=0, parity=0.
//  WIDTH=1 build: full truth table 00->0, 01->1, 10->1, 11->0 with parity==y.

Source files
------------

// File: rtl/cmos_xor_array.sv
// Registered WIDTH-bit XOR built from transistor-level CMOS slices, plus a registered
// even-parity flag. The datapath up to s[] is pure nmos/pmos switch primitives.
module cmos_xor_array #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             parity,
  output logic             out_valid
);

  supply1 vdd;
  supply0 gnd;

  tri [WIDTH-1:0] s;

  logic [WIDTH-1:0] y_q, y_d;
  logic             parity_q, parity_d;
  logic             out_valid_q, out_valid_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    tri na, nb, u, x, mb, ma;

    pmos pia (na, vdd, a[i]);
    nmos nia (na, gnd, a[i]);
    pmos pib (nb, vdd, b[i]);
    nmos nib (nb, gnd, b[i]);

    // Pull-up conducts when (a | ~b) & (~a | b), so x is the XNOR of the operands.
    pmos p1 (u, vdd, na);
    pmos p2 (u, vdd, b[i]);
    pmos p3 (x, u, a[i]);
    pmos p4 (x, u, nb);

    nmos n2 (mb, gnd, na);
    nmos n1 (x, mb, b[i]);
    nmos n4 (ma, gnd, a[i]);
    nmos n3 (x, ma, nb);

    pmos p5 (s[i], vdd, x);
    nmos n5 (s[i], gnd, x);
  end

  // Capture stage: parity is taken from s at capture, never from the held y.
  always_comb begin
    y_d         = y_q;
    parity_d    = parity_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      y_d         = s;
      parity_d    = ^s;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign parity    = parity_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cmos_xor_array.sv
// Bench for cmos_xor_array: a cycle-level reference model checked every cycle, plus
// hand-computed literal checks on directed vectors and a WIDTH=1 instance.
module tb_cmos_xor_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] y;
  logic       parity, out_valid;

  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] y1;
  logic       parity1, out_valid1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_y = '0;
  logic       m_par = 1'b0;
  logic       m_vld = 1'b0;

  cmos_xor_array #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .y(y), .parity(parity), .out_valid(out_valid)
  );

  cmos_xor_array #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
    .y(y1), .parity(parity1), .out_valid(out_valid1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: output is simply last accepted a^b and its popcount parity.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y   <= '0;
      m_par <= 1'b0;
      m_vld <= 1'b0;
    end else begin
      m_vld <= in_valid;
      if (in_valid) begin
        m_y   <= a ^ b;
        m_par <= ($countones(a ^ b) % 2) == 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_y", {24'd0, y}, {24'd0, m_y});
    chk("model_parity", {31'd0, parity}, {31'd0, m_par});
    chk("model_valid", {31'd0, out_valid}, {31'd0, m_vld});
  end

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic v);
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [7:0] ey, input logic ep, input logic ev);
    chk({nm, "_y"}, {24'd0, y}, {24'd0, ey});
    chk({nm, "_parity"}, {31'd0, parity}, {31'd0, ep});
    chk({nm, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
  endtask

  logic [3:0] tt;

  initial begin
    tt = 4'b0110;
    #2;
    lit("reset", 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    drive(8'h00, 8'h00, 1'b1); lit("ex00", 8'h00, 1'b0, 1'b1);
    drive(8'h00, 8'hFF, 1'b1); lit("ex01", 8'hFF, 1'b0, 1'b1);
    drive(8'hFF, 8'h00, 1'b1); lit("ex10", 8'hFF, 1'b0, 1'b1);
    drive(8'hFF, 8'hFF, 1'b1); lit("ex11", 8'h00, 1'b0, 1'b1);
    drive(8'h01, 8'h00, 1'b1); lit("odd", 8'h01, 1'b1, 1'b1);
    drive(8'h5A, 8'h5A, 1'b1); lit("same", 8'h00, 1'b0, 1'b1);
    drive(8'h07, 8'h10, 1'b1); lit("odd4", 8'h17, 1'b0, 1'b1);
    drive(8'h07, 8'h00, 1'b1); lit("odd3", 8'h07, 1'b1, 1'b1);

    drive(8'hAA, 8'h55, 1'b1); lit("hold_cap", 8'hFF, 1'b0, 1'b1);
    drive(8'h12, 8'h34, 1'b0); lit("hold1", 8'hFF, 1'b0, 1'b0);
    drive(8'h81, 8'h7E, 1'b0); lit("hold2", 8'hFF, 1'b0, 1'b0);

    drive(8'hF0, 8'hCC, 1'b1); lit("f0cc", 8'h3C, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hF0;
    b = 8'hCC;
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'hF0, 8'hCC, 1'b0); lit("post_rst1", 8'h00, 1'b0, 1'b0);
    drive(8'h0F, 8'h00, 1'b0); lit("post_rst2", 8'h00, 1'b0, 1'b0);
    drive(8'h0F, 8'h00, 1'b1); lit("first_cap", 8'h0F, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      drive(8'($urandom), 8'($urandom), 1'b1);
      chk("rand_valid", {31'd0, out_valid}, 32'd1);
    end
    drive(8'h00, 8'h00, 1'b0);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a1[0] = k[1];
      b1[0] = k[0];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("w1_y", {31'd0, y1[0]}, {31'd0, tt[k]});
      chk("w1_parity", {31'd0, parity1}, {31'd0, tt[k]});
      chk("w1_valid", {31'd0, out_valid1}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
